wb_bus_arbiter: RTL and testbench

Two-master, one-slave Wishbone B4 classic arbiter placed directly downstream of the core's instruction and data master ports; it merges them onto the single system bus. Master 0 connects to the core data port (dwbm_*), master 1 to the instruction port (iwbm_*). Simultaneous requests are resolved round-robin. A bus watchdog terminates any transfer the slave fails to acknowledge, so neither pipeline stage can hang.

---
 rtl/wb_arb_pkg.sv | 34 +++
 rtl/wb_bus_arbiter_if.sv | 29 ++
 rtl/wb_bus_arbiter_bus_watchdog.sv | 42 ++++
 rtl/wb_bus_arbiter.sv | 116 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
// Purpose: state encoding, master indices, instruction-master constants, bus widths
//          and the round-robin pick helper used by wb_bus_arbiter.
// Ports:   none (package).
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic M_DATA = 1'b0;
  localparam logic M_INST = 1'b1;

  // The instruction master only ever reads whole words.
  localparam logic [3:0] SEL_ALL = 4'hF;
  localparam logic       WE_READ = 1'b0;

  localparam int ADDR_W = 32;
  localparam int DAT_W  = 32;
  localparam int SEL_W  = 4;

  // Round-robin pick: on contention the master not granted last time wins.
  function automatic logic pick_master(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end else if (req1) begin
      return M_INST;
    end else begin
      return M_DATA;
    end
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - Wishbone B4 classic bus bundle with master/slave views
// Purpose: one point-to-point Wishbone link (request + termination + data).
// Ports:   none; signals cyc, stb, we, sel, addr, wdata (master driven) and
//          rdata, ack, err (slave driven). Modport master drives the request,
//          modport slave answers it.
interface wb_bus_arbiter_if;
  import wb_arb_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DAT_W-1:0]  wdata;
  logic [DAT_W-1:0]  rdata;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack, err
  );

endinterface

// File: rtl/wb_bus_arbiter_bus_watchdog.sv
// rtl/wb_bus_arbiter_bus_watchdog.sv - cycle counter that flags an unanswered bus transfer
// Purpose: counts enabled cycles since the last clear and raises expired while the
//          count equals TIMEOUT_CYCLES; TIMEOUT_CYCLES of 0 disables it.
// Ports:   clk_i clock, rst_i async active-low reset, clear synchronous count clear,
//          count_en increment enable, expired combinational timeout flag.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_wd;
      assign unused_wd = ^{clk_i, rst_i, clear, count_en};
      assign expired   = 1'b0;
    end else begin : g_enabled
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
      logic [CNT_W-1:0] count;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (count_en && (count != LIMIT)) begin
          // Holding at LIMIT keeps the counter from wrapping past the flag.
          count <= count + CNT_W'(1);
        end
      end

      assign expired = (count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin two-master to one-slave Wishbone B4 classic arbiter
// Purpose: merges the core data master (m0) and instruction master (m1) onto one
//          system bus, with a watchdog that errors out unanswered transfers.
// Ports:   clk_i clock; rst_i async active-low reset;
//          m0 data master link (slave view), m1 instruction master link (slave view,
//          read-only: its we/sel/wdata are ignored); s system bus link (master view).
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_bus_arbiter_if.slave   m0,
  wb_bus_arbiter_if.slave   m1,
  wb_bus_arbiter_if.master  s
);

  arb_state_e state;
  logic       grant;
  logic       last_grant;

  logic req0, req1, next_grant;
  logic busy, g_cyc, g_stb, live, drive;
  logic expired, wd_clear, wd_count_en;
  logic term_ack, term_err;

  logic unused_m1;
  assign unused_m1 = ^{m1.we, m1.sel, m1.wdata};

  assign req0       = m0.cyc & m0.stb;
  assign req1       = m1.cyc & m1.stb;
  assign next_grant = pick_master(req0, req1, last_grant);

  assign busy  = (state == BUSY);
  assign g_cyc = (grant == M_INST) ? m1.cyc : m0.cyc;
  assign g_stb = (grant == M_INST) ? m1.stb : m0.stb;

  // live: a transfer the granted master still owns. Dropping cyc aborts it at once.
  assign live  = busy & g_cyc;
  // drive: slave-facing outputs are valid; a watchdog expiry pulls the bus away.
  assign drive = live & ~expired;

  // Ack wins over both slave err and watchdog expiry in the same cycle.
  assign term_ack = live & s.ack;
  assign term_err = live & ~s.ack & (s.err | expired);

  assign wd_clear    = ~busy;
  assign wd_count_en = live & ~s.ack & ~s.err;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (expired)
  );

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.addr  = '0;
    s.wdata = '0;
    if (drive) begin
      s.cyc = 1'b1;
      s.stb = g_stb;
      if (grant == M_INST) begin
        s.we    = WE_READ;
        s.sel   = SEL_ALL;
        s.addr  = m1.addr;
        s.wdata = '0;
      end else begin
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
      end
    end
  end

  assign m0.ack   = term_ack & (grant == M_DATA);
  assign m0.err   = term_err & (grant == M_DATA);
  assign m1.ack   = term_ack & (grant == M_INST);
  assign m1.err   = term_err & (grant == M_INST);
  assign m0.rdata = busy ? s.rdata : '0;
  assign m1.rdata = busy ? s.rdata : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      grant      <= M_DATA;
      last_grant <= M_INST;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!g_cyc || s.ack || s.err || expired) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

  logic clk_i;
  logic rst_i;
  int   n_total;
  int   n_pass;
  int   n_fail;

  wb_bus_arbiter_if m0_bus ();
  wb_bus_arbiter_if m1_bus ();
  wb_bus_arbiter_if s_bus ();

  wb_bus_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_bus.cyc   = req;
    m0_bus.stb   = req;
    m0_bus.we    = we;
    m0_bus.sel   = sel;
    m0_bus.addr  = addr;
    m0_bus.wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic [31:0] addr);
    m1_bus.cyc  = req;
    m1_bus.stb  = req;
    m1_bus.addr = addr;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst_i   = 1'b1;
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 32'h0);
    // Junk on the instruction master's write path must never reach the slave.
    m1_bus.we    = 1'b1;
    m1_bus.sel   = 4'h0;
    m1_bus.wdata = 32'hFFFF_FFFF;
    s_bus.ack    = 1'b0;
    s_bus.err    = 1'b0;
    s_bus.rdata  = 32'h1234_5678;
    #1 rst_i = 1'b0;
    #2;

    // Reset state
    chk("rst_s_cyc",    s_bus.cyc,    0);
    chk("rst_s_stb",    s_bus.stb,    0);
    chk("rst_s_addr",   s_bus.addr,   0);
    chk("rst_m0_ack",   m0_bus.ack,   0);
    chk("rst_m1_err",   m1_bus.err,   0);
    chk("rst_m0_rdata", m0_bus.rdata, 0);
    chk("rst_m1_rdata", m1_bus.rdata, 0);
    step();
    step();
    rst_i = 1'b1;
    step();

    // Single data write, ack in second BUSY cycle
    set_m0(1'b1, 1'b1, 4'h3, 32'h8000_0100, 32'hDEAD_BEEF);
    #1;
    chk("wr_idle_cyc", s_bus.cyc, 0);
    step();
    chk("wr_s_cyc",   s_bus.cyc,   1);
    chk("wr_s_stb",   s_bus.stb,   1);
    chk("wr_s_we",    s_bus.we,    1);
    chk("wr_s_sel",   s_bus.sel,   4'h3);
    chk("wr_s_addr",  s_bus.addr,  32'h8000_0100);
    chk("wr_s_wdata", s_bus.wdata, 32'hDEAD_BEEF);
    chk("wr_m0_ack_early", m0_bus.ack, 0);
    step();
    s_bus.ack = 1'b1;
    #1;
    chk("wr_m0_ack", m0_bus.ack, 1);
    chk("wr_m1_ack", m1_bus.ack, 0);
    step();
    s_bus.ack = 1'b0;
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("wr_m0_ack_once", m0_bus.ack, 0);
    chk("wr_after_cyc",   s_bus.cyc,  0);

    // Simultaneous requests right after reset: m0 first
    rst_i = 1'b0;
    #3 rst_i = 1'b1;
    set_m0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    set_m1(1'b1, 32'h8000_0000);
    step();
    chk("sim_first_addr", s_bus.addr, 32'h0000_0010);
    chk("sim_first_we",   s_bus.we,   0);
    s_bus.ack   = 1'b1;
    s_bus.rdata = 32'hCAFE_F00D;
    #1;
    chk("sim_m0_ack",   m0_bus.ack,   1);
    chk("sim_m1_noack", m1_bus.ack,   0);
    chk("sim_m0_rdata", m0_bus.rdata, 32'hCAFE_F00D);
    chk("sim_m1_rdata", m1_bus.rdata, 32'hCAFE_F00D);
    step();
    s_bus.ack = 1'b0;
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("sim_gap_cyc", s_bus.cyc, 0);
    step();
    chk("sim_m1_addr",  s_bus.addr,  32'h8000_0000);
    chk("sim_m1_sel",   s_bus.sel,   4'hF);
    chk("sim_m1_we",    s_bus.we,    0);
    chk("sim_m1_wdata", s_bus.wdata, 0);
    s_bus.ack = 1'b1;
    #1;
    chk("sim_m1_ack",   m1_bus.ack, 1);
    chk("sim_m0_noack", m0_bus.ack, 0);
    step();
    s_bus.ack = 1'b0;
    set_m1(1'b0, 32'h0);

    // Continuous contention: grants alternate starting from m0
    set_m0(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    set_m1(1'b1, 32'h0000_0200);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_grant_%0d", i), s_bus.addr,
          (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      s_bus.ack = 1'b1;
      step();
      s_bus.ack = 1'b0;
    end
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 32'h0);
    step();

    // Watchdog expiry on m1 with a silent slave
    set_m1(1'b1, 32'h0000_0300);
    step();
    chk("wd_c0_cyc", s_bus.cyc,  1);
    chk("wd_c0_err", m1_bus.err, 0);
    step();
    step();
    step();
    chk("wd_c3_err", m1_bus.err, 0);
    chk("wd_c3_cyc", s_bus.cyc,  1);
    step();
    chk("wd_c4_err",   m1_bus.err, 1);
    chk("wd_c4_cyc",   s_bus.cyc,  0);
    chk("wd_c4_stb",   s_bus.stb,  0);
    chk("wd_c4_m0err", m0_bus.err, 0);
    step();
    chk("wd_idle_cyc", s_bus.cyc,  0);
    chk("wd_idle_err", m1_bus.err, 0);
    set_m1(1'b0, 32'h0);
    step();

    // Watchdog expiry coinciding with a slave ack: ack only
    set_m1(1'b1, 32'h0000_0300);
    step();
    step();
    step();
    step();
    step();
    s_bus.ack = 1'b1;
    #1;
    chk("wdack_ack", m1_bus.ack, 1);
    chk("wdack_err", m1_bus.err, 0);
    step();
    s_bus.ack = 1'b0;
    set_m1(1'b0, 32'h0);
    #1;
    chk("wdack_idle_cyc", s_bus.cyc, 0);
    step();

    // Abort: m0 drops cyc in its second BUSY cycle, m1 pending
    set_m0(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
    set_m1(1'b1, 32'h0000_0500);
    step();
    chk("ab_c0_addr", s_bus.addr, 32'h0000_0400);
    chk("ab_c0_cyc",  s_bus.cyc,  1);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    s_bus.ack = 1'b1;
    #1;
    chk("ab_cyc",    s_bus.cyc,  0);
    chk("ab_stb",    s_bus.stb,  0);
    chk("ab_m0_ack", m0_bus.ack, 0);
    chk("ab_m1_ack", m1_bus.ack, 0);
    step();
    s_bus.ack = 1'b0;
    #1;
    chk("ab_idle_cyc", s_bus.cyc, 0);
    step();
    chk("ab_m1_addr", s_bus.addr, 32'h0000_0500);
    chk("ab_m1_cyc",  s_bus.cyc,  1);
    s_bus.ack = 1'b1;
    step();
    s_bus.ack = 1'b0;
    set_m1(1'b0, 32'h0);
    step();

    // Reset asserted between edges in the middle of an m0 transfer
    set_m0(1'b1, 1'b1, 4'h1, 32'h0000_0600, 32'h0000_00AA);
    step();
    chk("rm_pre_cyc", s_bus.cyc, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("rm_cyc", s_bus.cyc, 0);
    chk("rm_stb", s_bus.stb, 0);
    step();
    rst_i = 1'b1;
    set_m0(1'b1, 1'b0, 4'hF, 32'h0000_0700, 32'h0);
    set_m1(1'b1, 32'h0000_0800);
    step();
    chk("rm_win_addr", s_bus.addr, 32'h0000_0700);
    s_bus.ack = 1'b1;
    #1;
    chk("rm_win_ack", m0_bus.ack, 1);
    step();
    s_bus.ack = 1'b0;
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
